slip_interval_timer: RTL
========================

# slip_interval_timer

Programmable interval timer for the Slipstream peripheral area. It is the host-facing consumer of the loadable down-counter chain: the CPU loads a 16-bit reload value through the 8-bit register bus, and the counter decrements on prescaler ticks. The block raises a terminal-count pulse and a maskable interrupt, and the host reads a coherent, latched count back byte by byte.

## Interface
- WIDTH, 16: counter and reload width; byte lanes are fixed at 8 bits, and WIDTH is 16 in all instances.
- MasterClock  in  1  system clock; every register in the block is clocked on its rising edge.
- RST  in  1  synchronous, active-high reset.
- tick  in  1  count enable from the prescaler; one-cycle strobe.
- din  in  8  host write data.
- wr_lo  in  1  strobe: write reload[7:0].
- wr_hi  in  1  strobe: write reload[15:8] and request a count load.
- ctrl_wr  in  1  strobe: write control. din[0]=run, din[1]=periodic, din[2]=irq_ack (write-1-to-clear), din[3]=irq_en.
- latch  in  1  strobe: snapshot the count.
- rd_sel  in  1  0 selects the snapshot low byte on dout, 1 selects the high byte.
- dout  out  8  read data; combinational from the snapshot register.
- tc  out  1  registered terminal-count pulse, one cycle wide.
- irq  out  1  irq_pend AND irq_en; level output.

## Operation
- Registers:
  - reload[15:0]
  - count[15:0]
  - snap[15:0]
  - run, periodic, irq_en, irq_pend
  - load_req (internal)
- State is held in the run and periodic bits.
  - Run states: IDLE (run=0), PERIODIC (run=1, periodic=1), ONESHOT (run=1, periodic=0).
  - ctrl_wr moves between these states directly.
- wr_lo updates reload[7:0] only. It does not load the count.
- wr_hi updates reload[15:8] and loads count with the full new reload value {din, reload[7:0]} on the same edge. The load is unconditional, independent of run.
- Tick rule, evaluated when run=1, tick=1 and there is no wr_hi in that cycle:
  - If count != 0: count <= count - 1.
  - If count == 0: tc fires and irq_pend <= 1.
    - PERIODIC: count <= reload.
    - ONESHOT: count stays at 0 and run <= 0, which returns the block to IDLE.
- reload = 0 in PERIODIC produces a tc on every tick.
- The counter never wraps below zero. Terminal count is detected at 0, so the period is reload+1 ticks.
- latch: snap <= count, using the register value before this cycle's update. snap holds until the next latch.
- ctrl_wr with din[2]=1 clears irq_pend. run, periodic and irq_en take din[0], din[1] and din[3].
- Simultaneous events:
  - wr_hi and tick in the same cycle: the load wins and the tick is dropped.
  - irq_ack and a new terminal count in the same cycle: the set wins, so irq_pend=1.
  - ctrl_wr with run=0 and a terminal-count tick in the same cycle: the control write wins, so there is no tc and no irq set.
  - wr_lo and wr_hi in the same cycle: both bytes take din, and the count loads {din, din}.
- Reset values: reload, count, snap = 0; run, periodic, irq_en, irq_pend, tc = 0; irq = 0; dout = 0.
- RST mid-count aborts the count immediately. No tc is emitted.

## Timing
- Writes take effect on the edge of the strobe cycle and are visible on the following cycle.
- tc is asserted in cycle n+1 for a terminal-count tick in cycle n.
- irq rises in the same cycle as tc (when irq_en=1).
- After wr_hi in cycle n, the earliest decrement is a tick in cycle n+1.
- dout follows rd_sel combinationally. It changes in cycle n+1 after a latch in cycle n.
- irq falls in cycle n+1 after an ack in cycle n.
- Clearing irq_en masks irq without clearing irq_pend.

## Structure
- Shared package slip_timer_pkg holds:
  - control bit position constants CTRL_RUN=0, CTRL_PER=1, CTRL_ACK=2, CTRL_IEN=3;
  - the reload-width constant.
- Sub-module slip_timer_count holds the loadable down-counter datapath: load/decrement/hold, zero detect, and a per-bit carry chain.
  - The top level holds the control registers, snapshot, irq logic and the read mux.

## Test plan
- Reset, then reload=0x0003 written via wr_lo/wr_hi, then ctrl_wr 0x0B, then tick every cycle -> count 3,2,1,0; tc after the 4th tick; count reloads to 3; tc repeats every 4 ticks; irq=1 until ack.
- ONESHOT with reload=0x0002 and ticks on every cycle -> exactly one tc after the 3rd tick; run=0; count holds at 0; further ticks produce no tc.
- Count at 0x1234, then latch, then 5 further ticks -> dout=0x34 with rd_sel=0 and 0x12 with rd_sel=1, unchanged by the later ticks.
- wr_hi (din=0x00, reload[7:0]=0x10) in the same cycle as a tick with count=0 -> count=0x0010, no tc, irq_pend unchanged.
- irq_ack coincident with a terminal-count tick -> irq_pend stays 1, and tc pulses once.
- RST asserted for 1 cycle in PERIODIC mid-count -> all outputs 0 the next cycle; no tc afterwards without reprogramming.

Source files
------------

// File: rtl/slip_timer_pkg.sv
// Shared constants and helpers for the Slipstream interval timer.
// Control-register bit positions, reload width and the byte read selector.
package slip_timer_pkg;

    localparam int RELOAD_W = 16;
    localparam int BYTE_W   = 8;

    localparam int CTRL_RUN = 0;
    localparam int CTRL_PER = 1;
    localparam int CTRL_ACK = 2;
    localparam int CTRL_IEN = 3;

    function automatic logic [BYTE_W-1:0] byte_sel(input logic [RELOAD_W-1:0] v,
                                                   input logic                hi);
        return hi ? v[RELOAD_W-1:BYTE_W] : v[BYTE_W-1:0];
    endfunction

endpackage

// File: rtl/slip_timer_count.sv
// Loadable down-counter: load beats step; a step at zero either reloads or holds zero.
// The decrement is a ripple borrow chain whose borrow-out doubles as the zero flag.
module slip_timer_count
    import slip_timer_pkg::*;
#(
    parameter int WIDTH = RELOAD_W
) (
    input  logic             i_clk,
    input  logic             i_rst,
    input  logic             i_load,
    input  logic [WIDTH-1:0] i_load_val,
    input  logic             i_step,
    input  logic             i_wrap,
    input  logic [WIDTH-1:0] i_reload,
    output logic [WIDTH-1:0] o_count,
    output logic             o_zero
);

    logic [WIDTH-1:0] r_count;
    logic [WIDTH-1:0] w_dec;
    logic [WIDTH:0]   w_borrow;

    assign w_borrow[0] = 1'b1;

    // A borrow survives past every bit only when all bits are zero.
    for (genvar i = 0; i < WIDTH; i++) begin : g_borrow
        assign w_dec[i]      = r_count[i] ^ w_borrow[i];
        assign w_borrow[i+1] = w_borrow[i] & ~r_count[i];
    end

    assign o_zero  = w_borrow[WIDTH];
    assign o_count = r_count;

    // Count register: reset, load, terminal reload/hold, or decrement.
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_count <= {WIDTH{1'b0}};
        end else if (i_load) begin
            r_count <= i_load_val;
        end else if (i_step) begin
            if (o_zero) begin
                r_count <= i_wrap ? i_reload : {WIDTH{1'b0}};
            end else begin
                r_count <= w_dec;
            end
        end else begin
            r_count <= r_count;
        end
    end

endmodule

// File: rtl/slip_interval_timer.sv
// Host-facing programmable interval timer: byte-wide reload/control writes,
// terminal-count pulse, maskable interrupt and a latched byte-readable count.
module slip_interval_timer
    import slip_timer_pkg::*;
#(
    parameter int WIDTH = RELOAD_W
) (
    input  logic              MasterClock,
    input  logic              RST,
    input  logic              tick,
    input  logic [BYTE_W-1:0] din,
    input  logic              wr_lo,
    input  logic              wr_hi,
    input  logic              ctrl_wr,
    input  logic              latch,
    input  logic              rd_sel,
    output logic [BYTE_W-1:0] dout,
    output logic              tc,
    output logic              irq
);

    logic [WIDTH-1:0] r_reload;
    logic [WIDTH-1:0] r_snap;
    logic             r_run;
    logic             r_periodic;
    logic             r_irq_en;
    logic             r_irq_pend;
    logic             r_tc;

    logic [WIDTH-1:0] w_count;
    logic [WIDTH-1:0] w_load_val;
    logic             w_zero;
    logic             w_ctrl_stop;
    logic             w_step;
    logic             w_tc;

    // A load or a stopping control write in the same cycle swallows the tick.
    always_comb begin
        w_ctrl_stop = ctrl_wr & ~din[CTRL_RUN];
        w_step      = r_run & tick & ~wr_hi & ~w_ctrl_stop;
        w_tc        = w_step & w_zero;
        w_load_val  = {din, (wr_lo ? din : r_reload[BYTE_W-1:0])};
    end

    slip_timer_count #(
        .WIDTH (WIDTH)
    ) u_count (
        .i_clk      (MasterClock),
        .i_rst      (RST),
        .i_load     (wr_hi),
        .i_load_val (w_load_val),
        .i_step     (w_step),
        .i_wrap     (r_periodic),
        .i_reload   (r_reload),
        .o_count    (w_count),
        .o_zero     (w_zero)
    );

    // Reload register byte lanes.
    always_ff @(posedge MasterClock) begin
        if (RST) begin
            r_reload <= {WIDTH{1'b0}};
        end else begin
            if (wr_lo) r_reload[BYTE_W-1:0]     <= din;
            if (wr_hi) r_reload[WIDTH-1:BYTE_W] <= din;
        end
    end

    // Run-state bits: a control write wins over a one-shot expiry.
    always_ff @(posedge MasterClock) begin
        if (RST) begin
            r_run      <= 1'b0;
            r_periodic <= 1'b0;
            r_irq_en   <= 1'b0;
        end else if (ctrl_wr) begin
            r_run      <= din[CTRL_RUN];
            r_periodic <= din[CTRL_PER];
            r_irq_en   <= din[CTRL_IEN];
        end else if (w_tc && !r_periodic) begin
            r_run <= 1'b0;
        end
    end

    // Pending interrupt: a new terminal count beats an acknowledge.
    always_ff @(posedge MasterClock) begin
        if (RST) begin
            r_irq_pend <= 1'b0;
        end else if (w_tc) begin
            r_irq_pend <= 1'b1;
        end else if (ctrl_wr && din[CTRL_ACK]) begin
            r_irq_pend <= 1'b0;
        end
    end

    // Terminal-count pulse and count snapshot.
    always_ff @(posedge MasterClock) begin
        if (RST) begin
            r_tc   <= 1'b0;
            r_snap <= {WIDTH{1'b0}};
        end else begin
            r_tc <= w_tc;
            if (latch) r_snap <= w_count;
        end
    end

    assign tc   = r_tc;
    assign irq  = r_irq_pend & r_irq_en;
    assign dout = byte_sel(r_snap, rd_sel);

endmodule
